// File: rtl/insn_decode_stage.sv
// Instruction decode stage: accepts issued instructions over a valid/ready
// handshake, decodes the 12-bit class field into execute/memory controls and
// presents them from a registered main entry backed by one skid entry.
module insn_decode_stage #(
  parameter int REG_BITS  = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [31:0]          i_opcode,
  input  logic [31:0]          i_oprand1,
  input  logic [31:0]          i_oprand2,
  input  logic [31:0]          i_oprand3,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [2:0]           o_alu_op,
  output logic                 o_use_imm,
  output logic                 o_mem_rd,
  output logic                 o_mem_wr,
  output logic                 o_stack_op,
  output logic                 o_svc,
  output logic                 o_illegal,
  output logic [REG_BITS-1:0]  o_rd,
  output logic [REG_BITS-1:0]  o_rn,
  output logic [REG_BITS-1:0]  o_rm,
  output logic [31:0]          o_imm,
  output logic [CNT_WIDTH-1:0] o_insn_count,
  output logic [CNT_WIDTH-1:0] o_ill_count
);

  localparam logic [2:0]  ALU_NONE = 3'd0;
  localparam logic [2:0]  ALU_MOV  = 3'd1;
  localparam logic [2:0]  ALU_ADD  = 3'd2;
  localparam logic [2:0]  ALU_SUB  = 3'd3;
  localparam logic [2:0]  ALU_AND  = 3'd4;
  localparam logic [2:0]  ALU_ORR  = 3'd5;
  localparam logic [31:0] NUM_REGS = 32'd1 << REG_BITS;

  typedef struct packed {
    logic [2:0]          alu_op;
    logic                use_imm;
    logic                mem_rd;
    logic                mem_wr;
    logic                stack_op;
    logic                svc;
    logic                illegal;
    logic [REG_BITS-1:0] rd;
    logic [REG_BITS-1:0] rn;
    logic [REG_BITS-1:0] rm;
    logic [31:0]         imm;
  } ctrl_t;

  ctrl_t                w_dec;
  logic                 w_use_rd;
  logic                 w_use_rn;
  logic                 w_use_rm;
  logic                 w_known;
  logic                 w_bad_idx;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_unused;

  ctrl_t                r_main;
  ctrl_t                r_skid;
  logic                 r_main_valid;
  logic                 r_skid_valid;
  logic                 r_in_ready;
  logic [CNT_WIDTH-1:0] r_insn_count;
  logic [CNT_WIDTH-1:0] r_ill_count;

  // Upper opcode bits carry no meaning for this stage.
  assign w_unused = ^i_opcode[31:12];

  assign w_in_fire  = i_in_valid & r_in_ready;
  assign w_out_fire = r_main_valid & i_out_ready;

  // Decode class field; only operands the class uses as register indices are range-checked.
  always_comb begin
    w_dec    = '0;
    w_dec.rd = i_oprand1[REG_BITS-1:0];
    w_dec.rn = i_oprand3[REG_BITS-1:0];
    w_dec.rm = i_oprand2[REG_BITS-1:0];
    w_dec.imm = i_oprand2;
    w_use_rd = 1'b0;
    w_use_rn = 1'b0;
    w_use_rm = 1'b0;
    w_known  = 1'b1;
    case (i_opcode[11:0])
      12'hE1A: begin w_dec.alu_op = ALU_MOV; w_use_rd = 1'b1; w_use_rm = 1'b1; end
      12'hE3A: begin w_dec.alu_op = ALU_MOV; w_dec.use_imm = 1'b1; w_use_rd = 1'b1; end
      12'hE08: begin w_dec.alu_op = ALU_ADD; w_use_rd = 1'b1; w_use_rn = 1'b1; w_use_rm = 1'b1; end
      12'hE28: begin w_dec.alu_op = ALU_ADD; w_dec.use_imm = 1'b1; w_use_rd = 1'b1; w_use_rn = 1'b1; end
      12'hE04: begin w_dec.alu_op = ALU_SUB; w_use_rd = 1'b1; w_use_rn = 1'b1; w_use_rm = 1'b1; end
      12'hE24: begin w_dec.alu_op = ALU_SUB; w_dec.use_imm = 1'b1; w_use_rd = 1'b1; w_use_rn = 1'b1; end
      12'hE00: begin w_dec.alu_op = ALU_AND; w_use_rd = 1'b1; w_use_rn = 1'b1; w_use_rm = 1'b1; end
      12'hE20: begin w_dec.alu_op = ALU_AND; w_dec.use_imm = 1'b1; w_use_rd = 1'b1; w_use_rn = 1'b1; end
      12'hE18: begin w_dec.alu_op = ALU_ORR; w_use_rd = 1'b1; w_use_rn = 1'b1; w_use_rm = 1'b1; end
      12'hE38: begin w_dec.alu_op = ALU_ORR; w_dec.use_imm = 1'b1; w_use_rd = 1'b1; w_use_rn = 1'b1; end
      12'hE59: begin w_dec.mem_rd = 1'b1; w_use_rd = 1'b1; w_use_rn = 1'b1; w_use_rm = 1'b1; end
      12'hE49: begin w_dec.mem_rd = 1'b1; w_dec.stack_op = 1'b1; w_use_rd = 1'b1; end
      12'hE78: begin w_dec.mem_wr = 1'b1; w_use_rd = 1'b1; w_use_rn = 1'b1; w_use_rm = 1'b1; end
      12'hE58: begin w_dec.mem_wr = 1'b1; w_dec.use_imm = 1'b1; w_use_rd = 1'b1; w_use_rn = 1'b1; end
      12'hE52: begin w_dec.mem_wr = 1'b1; w_dec.stack_op = 1'b1; w_use_rd = 1'b1; end
      12'hEF0: begin w_dec.svc = 1'b1; end
      default: w_known = 1'b0;
    endcase
    // Gating by the use flags keeps X on unused operands from reaching the result.
    w_bad_idx = (w_use_rd && (i_oprand1 >= NUM_REGS)) ||
                (w_use_rn && (i_oprand3 >= NUM_REGS)) ||
                (w_use_rm && (i_oprand2 >= NUM_REGS));
    if (!w_known || w_bad_idx) begin
      w_dec.alu_op   = ALU_NONE;
      w_dec.use_imm  = 1'b0;
      w_dec.mem_rd   = 1'b0;
      w_dec.mem_wr   = 1'b0;
      w_dec.stack_op = 1'b0;
      w_dec.svc      = 1'b0;
      w_dec.illegal  = 1'b1;
    end
  end

  // Main/skid buffer: main only changes when empty or consumed, so a stalled output holds.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (!r_main_valid || w_out_fire) begin
      if (r_skid_valid) begin
        // in_ready is low while skid is full, so no new input can collide here.
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else begin
        r_main_valid <= w_in_fire;
        if (w_in_fire) begin
          r_main <= w_dec;
        end
      end
    end else if (w_in_fire) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end

  // Saturating statistics counters, stepped on each accepted instruction.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_insn_count <= '0;
      r_ill_count  <= '0;
    end else if (w_in_fire) begin
      if (r_insn_count != '1) begin
        r_insn_count <= r_insn_count + CNT_WIDTH'(1);
      end
      if (w_dec.illegal && (r_ill_count != '1)) begin
        r_ill_count <= r_ill_count + CNT_WIDTH'(1);
      end
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_out_valid  = r_main_valid;
  assign o_alu_op     = r_main.alu_op;
  assign o_use_imm    = r_main.use_imm;
  assign o_mem_rd     = r_main.mem_rd;
  assign o_mem_wr     = r_main.mem_wr;
  assign o_stack_op   = r_main.stack_op;
  assign o_svc        = r_main.svc;
  assign o_illegal    = r_main.illegal;
  assign o_rd         = r_main.rd;
  assign o_rn         = r_main.rn;
  assign o_rm         = r_main.rm;
  assign o_imm        = r_main.imm;
  assign o_insn_count = r_insn_count;
  assign o_ill_count  = r_ill_count;

endmodule

// File: tb/tb_insn_decode_stage.sv
// Bench for insn_decode_stage: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a table-driven reference decoder.
module tb_insn_decode_stage;

  localparam int RB  = 4;
  localparam int CW  = 6;
  localparam int SAT = (1 << CW) - 1;

  typedef struct packed {
    logic [2:0]    alu;
    logic          use_imm;
    logic          mem_rd;
    logic          mem_wr;
    logic          stack_op;
    logic          svc;
    logic          ill;
    logic [RB-1:0] rd;
    logic [RB-1:0] rn;
    logic [RB-1:0] rm;
    logic [31:0]   imm;
  } exp_t;

  // Class table: code, ALU op, flags {imm, mem_rd, mem_wr, stack, svc, uses_rd, uses_rn, uses_rm}
  localparam logic [11:0] CLS_CODE [16] = '{12'hE1A, 12'hE3A, 12'hE08, 12'hE28, 12'hE04, 12'hE24,
                                             12'hE00, 12'hE20, 12'hE18, 12'hE38, 12'hE59, 12'hE49,
                                             12'hE78, 12'hE58, 12'hE52, 12'hEF0};
  localparam logic [2:0]  CLS_ALU  [16] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4,
                                             3'd5, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
  localparam logic [7:0]  CLS_FLG  [16] = '{8'b00000_101, 8'b10000_100, 8'b00000_111, 8'b10000_110,
                                             8'b00000_111, 8'b10000_110, 8'b00000_111, 8'b10000_110,
                                             8'b00000_111, 8'b10000_110, 8'b01000_111, 8'b01010_100,
                                             8'b00100_111, 8'b10100_110, 8'b00110_100, 8'b00001_000};

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_in_valid = 1'b0;
  logic          o_in_ready;
  logic [31:0]   i_opcode = '0;
  logic [31:0]   i_oprand1 = '0;
  logic [31:0]   i_oprand2 = '0;
  logic [31:0]   i_oprand3 = '0;
  logic          o_out_valid;
  logic          i_out_ready = 1'b0;
  logic [2:0]    o_alu_op;
  logic          o_use_imm, o_mem_rd, o_mem_wr, o_stack_op, o_svc, o_illegal;
  logic [RB-1:0] o_rd, o_rn, o_rm;
  logic [31:0]   o_imm;
  logic [CW-1:0] o_insn_count, o_ill_count;
  exp_t          w_act;

  int n_checks = 0;
  int n_fail = 0;
  exp_t sb_q[$];
  int m_insn = 0;
  int m_ill = 0;
  logic prev_stall = 1'b0;
  exp_t prev_act;

  insn_decode_stage #(.REG_BITS(RB), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_opcode(i_opcode), .i_oprand1(i_oprand1), .i_oprand2(i_oprand2), .i_oprand3(i_oprand3),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_alu_op(o_alu_op), .o_use_imm(o_use_imm), .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr),
    .o_stack_op(o_stack_op), .o_svc(o_svc), .o_illegal(o_illegal),
    .o_rd(o_rd), .o_rn(o_rn), .o_rm(o_rm), .o_imm(o_imm),
    .o_insn_count(o_insn_count), .o_ill_count(o_ill_count)
  );

  assign w_act = {o_alu_op, o_use_imm, o_mem_rd, o_mem_wr, o_stack_op, o_svc, o_illegal,
                  o_rd, o_rn, o_rm, o_imm};

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [31:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] c);
    exp_t e;
    int k;
    logic [7:0] f;
    e = '0;
    k = -1;
    e.rd = a[RB-1:0];
    e.rn = c[RB-1:0];
    e.rm = b[RB-1:0];
    e.imm = b;
    for (int i = 0; i < 16; i++) if (CLS_CODE[i] == op[11:0]) k = i;
    if (k < 0) begin
      e.ill = 1'b1;
      return e;
    end
    f = CLS_FLG[k];
    if ((f[2] && a > 32'd15) || (f[1] && c > 32'd15) || (f[0] && b > 32'd15)) begin
      e.ill = 1'b1;
      return e;
    end
    e.alu      = CLS_ALU[k];
    e.use_imm  = f[7];
    e.mem_rd   = f[6];
    e.mem_wr   = f[5];
    e.stack_op = f[4];
    e.svc      = f[3];
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: occupancy, counters, hold-while-stalled, then pop/push the scoreboard.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      sb_q.delete();
      m_insn = 0;
      m_ill = 0;
      prev_stall = 1'b0;
    end else begin
      chk("out_valid_occupancy", 64'(o_out_valid), 64'(sb_q.size() > 0));
      chk("in_ready_occupancy", 64'(o_in_ready), 64'(sb_q.size() < 2));
      chk("insn_count", 64'(o_insn_count), 64'(m_insn));
      chk("ill_count", 64'(o_ill_count), 64'(m_ill));
      if (prev_stall) begin
        chk("hold_valid", 64'(o_out_valid), 64'd1);
        chk("hold_fields", 64'(w_act), 64'(prev_act));
      end
      if (o_out_valid && i_out_ready && sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("decode", 64'(w_act), 64'(e));
      end
      if (i_in_valid && o_in_ready) begin
        exp_t e;
        e = model(i_opcode, i_oprand1, i_oprand2, i_oprand3);
        sb_q.push_back(e);
        if (m_insn < SAT) m_insn++;
        if (e.ill && m_ill < SAT) m_ill++;
      end
      prev_stall = o_out_valid && !i_out_ready;
      prev_act = w_act;
    end
  end

  task automatic send(input logic [31:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] c);
    int waited;
    waited = 0;
    i_in_valid = 1'b1;
    i_opcode = op;
    i_oprand1 = a;
    i_oprand2 = b;
    i_oprand3 = c;
    forever begin
      @(negedge i_clk);
      if (o_in_ready) break;
      waited++;
      if (waited > 40) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
        break;
      end
    end
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    i_in_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_out_valid", 64'(o_out_valid), 64'd0);
    chk("rst_in_ready", 64'(o_in_ready), 64'd1);
    chk("rst_insn_count", 64'(o_insn_count), 64'd0);
    chk("rst_ill_count", 64'(o_ill_count), 64'd0);
    chk("rst_fields", 64'(w_act), 64'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_reg();
    int s;
    s = $urandom_range(0, 7);
    if (s <= 5) return 32'($urandom_range(0, 15));
    if (s == 6) return 32'($urandom_range(16, 31));
    return $urandom;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) != 0) r[11:0] = CLS_CODE[$urandom_range(0, 15)];
    return r;
  endfunction

  initial begin
    int rdy_bias;
    do_reset();

    // movnum with immediate
    i_out_ready = 1'b1;
    send(32'h0000_0E3A, 32'd1, 32'd5, 32'd0);
    @(negedge i_clk);
    chk("t1_out_valid", 64'(o_out_valid), 64'd1);
    chk("t1_alu_op", 64'(o_alu_op), 64'd1);
    chk("t1_use_imm", 64'(o_use_imm), 64'd1);
    chk("t1_rd", 64'(o_rd), 64'd1);
    chk("t1_imm", 64'(o_imm), 64'd5);

    // strreg then ldr back-to-back
    do_reset();
    i_out_ready = 1'b1;
    send(32'h0000_0E78, 32'd1, 32'd1, 32'd1);
    chk("t2_mem_wr", 64'(o_mem_wr), 64'd1);
    send(32'h0000_0E59, 32'd0, 32'd1, 32'd1);
    @(negedge i_clk);
    chk("t2_mem_rd", 64'(o_mem_rd), 64'd1);
    chk("t2_insn_count", 64'(o_insn_count), 64'd2);

    // undefined class, then out-of-range register on addreg
    do_reset();
    i_out_ready = 1'b1;
    send(32'h0000_0E7F, 32'd1, 32'd2, 32'd3);
    @(negedge i_clk);
    chk("t3_illegal", 64'(o_illegal), 64'd1);
    chk("t3_alu_op", 64'(o_alu_op), 64'd0);
    chk("t3_mem", 64'({o_mem_rd, o_mem_wr}), 64'd0);
    chk("t3_ill_count", 64'(o_ill_count), 64'd1);
    @(posedge i_clk); #1;
    send(32'h0000_0E08, 32'd2, 32'd16, 32'd3);
    @(negedge i_clk);
    chk("t4_illegal", 64'(o_illegal), 64'd1);
    chk("t4_alu_op", 64'(o_alu_op), 64'd0);

    // back-pressure: two accepted, third blocked, then drained in order
    do_reset();
    i_out_ready = 1'b0;
    send(32'h0000_0E08, 32'd1, 32'd2, 32'd3);
    send(32'h0000_0E24, 32'd4, 32'd99, 32'd5);
    i_in_valid = 1'b1;
    i_opcode = 32'h0000_0E52;
    i_oprand1 = 32'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("t5_in_ready_low", 64'(o_in_ready), 64'd0);
      @(posedge i_clk); #1;
    end
    i_in_valid = 1'b0;
    i_out_ready = 1'b1;
    send(32'h0000_0E52, 32'd7, 32'd0, 32'd0);
    repeat (3) @(posedge i_clk);
    #1;

    // reset with both entries full: nothing replayed afterwards
    i_out_ready = 1'b0;
    send(32'h0000_0E1A, 32'd1, 32'd2, 32'd0);
    send(32'h0000_0EF0, 32'd0, 32'd0, 32'd0);
    @(negedge i_clk);
    chk("t6_full", 64'(o_in_ready), 64'd0);
    do_reset();
    i_out_ready = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;

    // randomized traffic with varying back-pressure; long enough to saturate counters
    rdy_bias = 5;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc % 100 == 0) rdy_bias = $urandom_range(1, 5);
      i_out_ready = ($urandom_range(0, 4) < rdy_bias);
      i_in_valid = ($urandom_range(0, 3) != 0);
      i_opcode = rand_op();
      i_oprand1 = rand_reg();
      i_oprand2 = rand_reg();
      i_oprand3 = rand_reg();
      @(posedge i_clk); #1;
    end
    i_in_valid = 1'b0;
    i_out_ready = 1'b1;
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    chk("drain_out_valid", 64'(o_out_valid), 64'd0);
    chk("insn_count_saturated", 64'(o_insn_count), 64'(SAT));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
